// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and request legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Stores only come in B/H/W; the unsigned encodings are load-only.
    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        if (we)
            return !(funct3 inside {F3_B, F3_H, F3_W});
        else
            return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load lanes and merges store
// data into a read word for sub-word read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_word[7:0];
        case (addr_lo)
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            2'd3:    byte_sel = mem_word[31:24];
            default: byte_sel = mem_word[7:0];
        endcase
        half_sel = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    end

    always_comb begin
        load_data = mem_word;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'b0, byte_sel};
            F3_HU:   load_data = {16'b0, half_sel};
            default: load_data = mem_word;
        endcase
    end

    always_comb begin
        merged_word = mem_word;
        case (funct3[1:0])
            2'b00: begin
                case (addr_lo)
                    2'd0:    merged_word[7:0]   = store_data[7:0];
                    2'd1:    merged_word[15:8]  = store_data[7:0];
                    2'd2:    merged_word[23:16] = store_data[7:0];
                    default: merged_word[31:24] = store_data[7:0];
                endcase
            end
            2'b01: begin
                if (addr_lo[1])
                    merged_word[31:16] = store_data[15:0];
                else
                    merged_word[15:0] = store_data[15:0];
            end
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: FSM that turns byte/half/word requests into word-wide
// memory accesses, using read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    // Request handshake: a request transfers on a rising edge where
    // req_valid and req_ready are both 1; req_ready is high only in IDLE.
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_fault,
    output logic                  mem_WE,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0] mem_WD,
    input  logic [DATA_WIDTH-1:0] mem_RD,
    output logic [2:0]            dbg_state
);

    lsu_state_t state, next_state;

    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] merged_q;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  req_bad;

    assign req_bad   = is_illegal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
    assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign dbg_state = state;

    lsu_align u_align (
        .funct3      (f3_q),
        .addr_lo     (addr_q[1:0]),
        .mem_word    (mem_RD),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_WE     = 1'b0;
        mem_A      = '0;
        mem_WD     = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)
                        next_state = RESP;
                    else if (!req_we)
                        next_state = LOAD;
                    else if (req_funct3 == F3_W)
                        next_state = WRITE;
                    else
                        next_state = READ;
                end
            end
            LOAD: begin
                mem_A      = word_addr;
                next_state = RESP;
            end
            READ: begin
                mem_A      = word_addr;
                next_state = WRITE;
            end
            WRITE: begin
                mem_A      = word_addr;
                mem_WE     = 1'b1;
                mem_WD     = (f3_q == F3_W) ? wdata_q : merged_q;
                next_state = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Response registers only change on entry to RESP, so they hold between responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            merged_q  <= '0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == READ)
                merged_q <= merged_word;
            if (next_state == RESP) begin
                rsp_fault <= (state == IDLE);
                rsp_rdata <= (state == LOAD) ? load_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit against a 256-byte word memory, with a
// byte-level reference model feeding a response scoreboard.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        mem_WE;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;
    logic [2:0]  dbg_state;

    logic [31:0] dmem [0:63];
    logic [7:0]  ref_bytes [0:255];

    logic [32:0] exp_q[$];
    int          cyc_q[$];
    int          cyc;
    int          n_checks;
    int          n_pass;
    int          we_cnt;
    int          rsp_cnt;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .mem_WE     (mem_WE),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_RD     (mem_RD),
        .dbg_state  (dbg_state)
    );

    // clock / reset / memory
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_RD = dmem[mem_A[7:2]];

    always @(posedge clk) begin
        if (mem_WE)
            dmem[mem_A[7:2]] <= mem_WD;
    end

    always @(posedge clk) cyc++;

    // scoreboard: compares each response pulse against the oldest expectation
    always @(negedge clk) begin
        if (mem_WE)
            we_cnt++;
        if (rsp_valid) begin
            logic [32:0] e;
            int          c;
            rsp_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_rsp: got fault=%0b rdata=%08h with nothing expected", rsp_fault, rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                if ({rsp_fault, rsp_rdata} !== e)
                    $display("FAIL rsp_data: got fault=%0b rdata=%08h, expected fault=%0b rdata=%08h",
                             rsp_fault, rsp_rdata, e[32], e[31:0]);
                else
                    n_pass++;
                n_checks++;
                if (cyc !== c)
                    $display("FAIL rsp_latency: response in cycle %0d, expected cycle %0d", cyc, c);
                else
                    n_pass++;
            end
        end
    end

    // reference model; lat counts cycles from acceptance edge to rsp_valid
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [32:0] e, output int lat);
        logic       bad;
        logic [7:0] a;
        logic [31:0] v;
        a   = addr[7:0];
        bad = 1'b0;
        if (we && f3 > 3'd2) bad = 1'b1;
        if (!we && (f3 == 3'd3 || f3 > 3'd5)) bad = 1'b1;
        if (f3[1:0] == 2'd1 && a[0]) bad = 1'b1;
        if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) bad = 1'b1;
        if (bad) begin
            e   = {1'b1, 32'h0};
            lat = 1;
        end else if (!we) begin
            lat = 2;
            if (f3[1:0] == 2'd0) begin
                v = {24'h0, ref_bytes[a]};
                if (!f3[2] && v[7]) v[31:8] = 24'hFFFFFF;
            end else if (f3[1:0] == 2'd1) begin
                v = {16'h0, ref_bytes[a + 8'd1], ref_bytes[a]};
                if (!f3[2] && v[15]) v[31:16] = 16'hFFFF;
            end else begin
                v = {ref_bytes[a + 8'd3], ref_bytes[a + 8'd2], ref_bytes[a + 8'd1], ref_bytes[a]};
            end
            e = {1'b0, v};
        end else begin
            e = 33'h0;
            ref_bytes[a] = wd[7:0];
            if (f3 != 3'd0) ref_bytes[a + 8'd1] = wd[15:8];
            if (f3 == 3'd2) begin
                ref_bytes[a + 8'd2] = wd[23:16];
                ref_bytes[a + 8'd3] = wd[31:24];
            end
            lat = (f3 == 3'd2) ? 2 : 3;
        end
    endtask

    // driver: waits for req_ready, records expectation at the acceptance edge
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit keep);
        int          guard;
        int          lat;
        logic [32:0] e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, expected 1", req_ready, guard);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        model(we, f3, addr, wd, e, lat);
        exp_q.push_back(e);
        cyc_q.push_back(cyc + lat - 1);
        if (!keep)
            req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_fault, mem_WE} !== 4'b1000)
            $display("FAIL reset_ctrl: ready/valid/fault/we=%b, expected 1000",
                     {req_ready, rsp_valid, rsp_fault, mem_WE});
        else
            n_pass++;
        n_checks++;
        if ({rsp_rdata, mem_A, mem_WD} !== 96'h0)
            $display("FAIL reset_data: rdata=%08h A=%08h WD=%08h, expected all 0", rsp_rdata, mem_A, mem_WD);
        else
            n_pass++;
        n_checks++;
        if (dbg_state !== 3'd0)
            $display("FAIL reset_state: state=%0d, expected 0", dbg_state);
        else
            n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_word();
        issue(1'b1, 3'b010, 32'h10, 32'hCAFEBABE, 1'b0);
        drain();
        n_checks++;
        if (dmem[4] !== 32'hCAFEBABE)
            $display("FAIL sw_mem: word 0x10=%08h, expected cafebabe", dmem[4]);
        else
            n_pass++;
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
        issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
        issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
        issue(1'b0, 3'b101, 32'h10, 32'h0, 1'b0);
        drain();
    endtask

    task automatic test_subword();
        int w0;
        w0 = we_cnt;
        issue(1'b1, 3'b000, 32'h11, 32'h000000EE, 1'b0);
        drain();
        n_checks++;
        if (dmem[4] !== 32'hCAFEEEBE)
            $display("FAIL sb_mem: word 0x10=%08h, expected cafeeebe", dmem[4]);
        else
            n_pass++;
        n_checks++;
        if (we_cnt - w0 !== 1)
            $display("FAIL sb_we_cycles: %0d write cycles, expected 1", we_cnt - w0);
        else
            n_pass++;
        w0 = we_cnt;
        issue(1'b1, 3'b001, 32'h12, 32'h00001234, 1'b0);
        drain();
        n_checks++;
        if (dmem[4] !== 32'h1234EEBE)
            $display("FAIL sh_mem: word 0x10=%08h, expected 1234eebe", dmem[4]);
        else
            n_pass++;
        n_checks++;
        if (we_cnt - w0 !== 1)
            $display("FAIL sh_we_cycles: %0d write cycles, expected 1", we_cnt - w0);
        else
            n_pass++;
    endtask

    task automatic test_fault();
        int          w0;
        logic [31:0] saved;
        w0    = we_cnt;
        saved = dmem[4];
        issue(1'b0, 3'b010, 32'h12, 32'h0, 1'b0);
        issue(1'b1, 3'b001, 32'h13, 32'hFFFF, 1'b0);
        issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
        issue(1'b1, 3'b100, 32'h10, 32'h77, 1'b0);
        drain();
        n_checks++;
        if (we_cnt !== w0)
            $display("FAIL fault_we: %0d write cycles, expected 0", we_cnt - w0);
        else
            n_pass++;
        n_checks++;
        if (dmem[4] !== saved)
            $display("FAIL fault_mem: word 0x10=%08h, expected %08h", dmem[4], saved);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] f3;
        logic       we;
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        issue(1'b1, 3'b000, 32'h14, 32'h000000A5, 1'b1);
        issue(1'b0, 3'b100, 32'h14, 32'h0, 1'b0);
        drain();
        n_checks++;
        if (dmem[5] !== 32'h000000A5)
            $display("FAIL b2b_mem: word 0x14=%08h, expected 000000a5", dmem[5]);
        else
            n_pass++;
        for (int i = 0; i < 30; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 5));
            issue(we, f3, 32'($urandom_range(32'h20, 32'h3F)), $urandom, 1'($urandom_range(0, 1)));
        end
        req_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        int          w0;
        int          r0;
        logic [31:0] saved;
        w0    = we_cnt;
        r0    = rsp_cnt;
        saved = dmem[4];
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h10;
        req_wdata  = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_checks++;
        if (dbg_state !== 3'd2)
            $display("FAIL rmw_in_read: state=%0d, expected 2", dbg_state);
        else
            n_pass++;
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_fault, mem_WE, dbg_state} !== 7'b1000000)
            $display("FAIL mid_reset_ctrl: ready/valid/fault/we/state=%b, expected 1000000",
                     {req_ready, rsp_valid, rsp_fault, mem_WE, dbg_state});
        else
            n_pass++;
        n_checks++;
        if ({rsp_rdata, mem_A, mem_WD} !== 96'h0)
            $display("FAIL mid_reset_data: rdata=%08h A=%08h WD=%08h, expected all 0", rsp_rdata, mem_A, mem_WD);
        else
            n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (we_cnt !== w0 || rsp_cnt !== r0)
            $display("FAIL mid_reset_quiet: %0d writes %0d responses, expected 0 and 0", we_cnt - w0, rsp_cnt - r0);
        else
            n_pass++;
        n_checks++;
        if (dmem[4] !== saved)
            $display("FAIL mid_reset_mem: word 0x10=%08h, expected %08h", dmem[4], saved);
        else
            n_pass++;
    endtask

    task automatic test_final_memory();
        int bad;
        bad = 0;
        for (int w = 0; w < 64; w++) begin
            if (dmem[w] !== {ref_bytes[w*4+3], ref_bytes[w*4+2], ref_bytes[w*4+1], ref_bytes[w*4]})
                bad++;
        end
        n_checks++;
        if (bad != 0)
            $display("FAIL final_memory: %0d words differ from reference, expected 0", bad);
        else
            n_pass++;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        cyc        = 0;
        n_checks   = 0;
        n_pass     = 0;
        we_cnt     = 0;
        rsp_cnt    = 0;
        for (int w = 0; w < 64; w++) dmem[w] = 32'h0;
        for (int b = 0; b < 256; b++) ref_bytes[b] = 8'h0;

        test_reset();
        test_word();
        test_subword();
        test_fault();
        test_back_to_back();
        test_reset_mid();
        test_final_memory();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
